// File: rtl/blink_core_sched.sv
// rtl/blink_core_sched.sv - arbitrates NREQ requesters onto one shared Blink core, with key-update drain
// Define BLINK_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module blink_core_sched #(
  parameter int N        = 128,
  parameter int TWEAKLEN = 128,
  parameter int ROUND    = 20,
  parameter int NREQ     = 2,
  parameter int IDW      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_enc,
  input  logic [NREQ*N-1:0]          req_p,
  input  logic [NREQ*TWEAKLEN-1:0]   req_t,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [N-1:0]               rsp_c,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic [N*(ROUND/2)-1:0]     key_k0,
  input  logic [509:0]               key_k1,
  output logic                       core_enc,
  output logic [N*(ROUND/2)-1:0]     core_k0,
  output logic [509:0]               core_k1,
  output logic [N-1:0]               core_p,
  output logic [TWEAKLEN-1:0]        core_t,
  input  logic [N-1:0]               core_c
);

  typedef enum logic [1:0] {K_RUN, K_DRAIN, K_LOAD} key_state_t;

  key_state_t            r_kstate;
  logic                  r_s1_valid;
  logic [IDW-1:0]        r_s1_id;
  logic                  w_s2_free;
  logic                  w_s1_free;
  logic                  w_s1_adv;
  logic                  w_grant_ok;
  logic                  w_accept;
  logic                  w_win_valid;
  logic [IDW-1:0]        w_win_id;
  int                    w_best;
  int                    w_dist;
  logic                  w_sel_enc;
  logic [N-1:0]          w_sel_p;
  logic [TWEAKLEN-1:0]   w_sel_t;

`ifndef BLINK_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]        r_last;
`endif

  assign w_s2_free  = !rsp_valid || rsp_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign w_s1_free  = !r_s1_valid || w_s2_free;
  // rst gates grants so nothing is offered while the pipeline is being cleared
  assign w_grant_ok = rst && w_s1_free && (r_kstate == K_RUN) && !key_valid;
  assign w_accept   = w_grant_ok && w_win_valid;

  // Winner = valid requester with the smallest distance from the current top priority
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_best      = NREQ;
    w_dist      = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef BLINK_SCHED_FIXED_PRIO_EN
      w_dist = i;
`else
      w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
`endif
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_win_id    = IDW'(i);
        w_win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_sel_enc = 1'b0;
    w_sel_p   = '0;
    w_sel_t   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_id == IDW'(i)) begin
        req_ready[i] = w_accept;
        w_sel_enc    = req_enc[i];
        w_sel_p      = req_p[i*N +: N];
        w_sel_t      = req_t[i*TWEAKLEN +: TWEAKLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      core_enc   <= 1'b0;
      core_p     <= '0;
      core_t     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_c      <= '0;
`ifndef BLINK_SCHED_FIXED_PRIO_EN
      r_last     <= IDW'(NREQ - 1);
`endif
    end else begin
      if (w_s1_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_s1_id;
        rsp_c     <= core_c;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_win_id;
        core_enc   <= w_sel_enc;
        core_p     <= w_sel_p;
        core_t     <= w_sel_t;
`ifndef BLINK_SCHED_FIXED_PRIO_EN
        r_last     <= w_win_id;
`endif
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Keys are only rewritten once the issue stage is empty, so no in-flight op sees a key change
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kstate  <= K_RUN;
      key_ready <= 1'b0;
      core_k0   <= '0;
      core_k1   <= '0;
    end else begin
      case (r_kstate)
        K_RUN: begin
          key_ready <= 1'b0;
          if (key_valid) r_kstate <= K_DRAIN;
        end
        K_DRAIN: begin
          if (!r_s1_valid) begin
            r_kstate  <= K_LOAD;
            key_ready <= 1'b1;
          end
        end
        K_LOAD: begin
          core_k0   <= key_k0;
          core_k1   <= key_k1;
          key_ready <= 1'b0;
          r_kstate  <= K_RUN;
        end
        default: begin
          key_ready <= 1'b0;
          r_kstate  <= K_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_core_sched.sv
// tb/tb_blink_core_sched.sv - self-checking bench for blink_core_sched with a stand-in invertible core
// Honours BLINK_SCHED_FIXED_PRIO_EN to select the expected arbitration.
module tb_blink_core_sched;
  localparam int N = 128, TL = 128, ROUND = 20, NREQ = 2, IDW = 1;
  localparam int KW = N*(ROUND/2), K1W = 510;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, req_enc;
  logic [NREQ*N-1:0] req_p;
  logic [NREQ*TL-1:0] req_t;
  logic rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0] rsp_c;
  logic key_valid, key_ready;
  logic [KW-1:0] key_k0, core_k0;
  logic [K1W-1:0] key_k1, core_k1;
  logic core_enc;
  logic [N-1:0] core_p, core_c;
  logic [TL-1:0] core_t;

  always #5 clk = ~clk;

  blink_core_sched #(.N(N), .TWEAKLEN(TL), .ROUND(ROUND), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc),
    .req_p(req_p), .req_t(req_t), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .key_valid(key_valid), .key_ready(key_ready), .key_k0(key_k0), .key_k1(key_k1),
    .core_enc(core_enc), .core_k0(core_k0), .core_k1(core_k1), .core_p(core_p), .core_t(core_t),
    .core_c(core_c));

  // Stand-in core: rotate-and-mask, exactly invertible with enc=0
  function automatic logic [N-1:0] core_f(input logic enc, input logic [N-1:0] x, input logic [TL-1:0] t,
                                          input logic [KW-1:0] k0, input logic [K1W-1:0] k1);
    logic [N-1:0] m, y;
    m = t ^ k0[N-1:0] ^ k0[KW-1 -: N] ^ k1[K1W-1 -: N] ^ {2{k1[63:0]}};
    if (enc) y = {x[N-4:0], x[N-1:N-3]} ^ m;
    else begin
      y = x ^ m;
      y = {y[2:0], y[N-1:3]};
    end
    return y;
  endfunction

  assign core_c = core_f(core_enc, core_p, core_t, core_k0, core_k1);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [KW-1:0] mk0, k2_0, rk0;
  logic [K1W-1:0] mk1, k2_1;
  logic [511:0] rtmp;

  task automatic do_key(input logic [KW-1:0] k0, input logic [K1W-1:0] k1, input int exp_wait);
    int w;
    w = 0;
    key_k0 = k0; key_k1 = k1; key_valid = 1'b1;
    #1;
    while (!key_ready && w < 20) begin
      step();
      w++;
      #1;
    end
    chk("key_wait", KW'(w), KW'(exp_wait));
    step();
    key_valid = 1'b0;
    #1;
    chk("key_ready_drop", KW'(key_ready), KW'(1'b0));
    chk("key_k0_commit", core_k0, k0);
    chk("key_k1_commit", KW'(core_k1), KW'(k1));
    mk0 = k0; mk1 = k1;
  endtask

  typedef struct {
    logic [1:0] vld; logic rr; logic [1:0] rdy_rr; logic [1:0] rdy_fp;
    logic rv; logic id_rr; logic id_fp;
  } vec_t;
  vec_t tbl[13];

  typedef struct { logic [IDW-1:0] id; logic [N-1:0] c; int acc; } item_t;
  item_t q[$];
  item_t nitem;

  localparam logic [N-1:0] P0 = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
  localparam logic [N-1:0] P1 = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
  localparam logic [TL-1:0] T0 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [TL-1:0] T1 = 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110;

  logic [N-1:0] c1, cx, cy, e_c;
  logic [1:0] e_rdy;
  logic e_id, e_rv, allowed, push, pop;
  int ec, ptr, win, idx;

  initial begin
    rst = 1'b0; req_valid = 2'b11; req_enc = '0; req_p = '0; req_t = '0;
    rsp_ready = 1'b0; key_valid = 1'b0; key_k0 = '0; key_k1 = '0;
    mk0 = '0; mk1 = '0;

    // reset state
    step(); step();
    chk("rst_req_ready", KW'(req_ready), KW'(2'b00));
    chk("rst_rsp_valid", KW'(rsp_valid), KW'(1'b0));
    chk("rst_key_ready", KW'(key_ready), KW'(1'b0));
    chk("rst_core_k0", core_k0, '0);
    chk("rst_core_p", KW'(core_p), '0);
    req_valid = 2'b00; rst = 1'b1;
    step();

    // test 1: all-ones keys, req0 P=1 T=0 encrypt
    do_key('1, '1, 2);
    req_valid = 2'b01; req_enc = 2'b01; req_p = {N'(0), N'(1)}; req_t = '0; rsp_ready = 1'b1;
    #1;
    chk("t1_ready", KW'(req_ready), KW'(2'b01));
    step();
    req_valid = 2'b00;
    #1;
    chk("t1_no_rsp_yet", KW'(rsp_valid), KW'(1'b0));
    step();
    chk("t1_rsp_valid", KW'(rsp_valid), KW'(1'b1));
    chk("t1_rsp_id", KW'(rsp_id), KW'(1'b0));
    c1 = core_f(1'b1, N'(1), '0, mk0, mk1);
    chk("t1_rsp_c", KW'(rsp_c), KW'(c1));
    step();
    chk("t1_rsp_drop", KW'(rsp_valid), KW'(1'b0));

    // test 6: decrypt the result via req1
    req_valid = 2'b10; req_enc = 2'b00; req_p = {c1, N'(0)};
    #1;
    chk("t6_ready", KW'(req_ready), KW'(2'b10));
    step();
    req_valid = 2'b00;
    step();
    chk("t6_rsp_id", KW'(rsp_id), KW'(1'b1));
    chk("t6_rsp_c", KW'(rsp_c), KW'(N'(1)));
    step();

    // tests 2/3: contention, then a 5-cycle response stall
    tbl[0]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0};
    for (int i = 4; i < 9; i++) tbl[i] = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    req_enc = 2'b11; req_p = {P1, P0}; req_t = {T1, T0};
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].vld; rsp_ready = tbl[i].rr;
`ifdef BLINK_SCHED_FIXED_PRIO_EN
      e_rdy = tbl[i].rdy_fp; e_id = tbl[i].id_fp;
`else
      e_rdy = tbl[i].rdy_rr; e_id = tbl[i].id_rr;
`endif
      #1;
      chk("tbl_ready", KW'(req_ready), KW'(e_rdy));
      chk("tbl_rsp_valid", KW'(rsp_valid), KW'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk("tbl_rsp_id", KW'(rsp_id), KW'(e_id));
        e_c = core_f(1'b1, e_id ? P1 : P0, e_id ? T1 : T0, mk0, mk1);
        chk("tbl_rsp_c", KW'(rsp_c), KW'(e_c));
      end
      step();
    end

    // test 4: key update while S1 full and response stalled
    for (int j = 0; j < KW/32; j++) k2_0[j*32 +: 32] = 32'h5A5A_0F0F ^ j;
    k2_1 = K1W'({16{32'h3C3C_A5A5}});
    cx = core_f(1'b1, P0, T0, mk0, mk1);
    cy = core_f(1'b1, P1, T1, mk0, mk1);
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1;
    chk("t4_fill0", KW'(req_ready), KW'(2'b01));
    step();
    req_valid = 2'b10;
    #1;
    chk("t4_fill1", KW'(req_ready), KW'(2'b10));
    step();
    req_valid = 2'b11; key_valid = 1'b1; key_k0 = k2_0; key_k1 = k2_1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_blocked", KW'(req_ready), KW'(2'b00));
      chk("t4_no_key_ready", KW'(key_ready), KW'(1'b0));
      chk("t4_rsp_id_stable", KW'(rsp_id), KW'(1'b0));
      chk("t4_rsp_c_stable", KW'(rsp_c), KW'(cx));
      chk("t4_old_k0", core_k0, mk0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_s6_key_ready", KW'(key_ready), KW'(1'b0));
    step();
    chk("t4_s7_key_ready", KW'(key_ready), KW'(1'b0));
    chk("t4_s7_ready", KW'(req_ready), KW'(2'b00));
    chk("t4_s7_rsp_id", KW'(rsp_id), KW'(1'b1));
    chk("t4_s7_rsp_c_oldkey", KW'(rsp_c), KW'(cy));
    step();
    chk("t4_key_ready", KW'(key_ready), KW'(1'b1));
    chk("t4_load_blocked", KW'(req_ready), KW'(2'b00));
    chk("t4_load_old_k0", core_k0, mk0);
    step();
    key_valid = 1'b0; req_valid = 2'b00;
    #1;
    chk("t4_key_ready_pulse", KW'(key_ready), KW'(1'b0));
    chk("t4_new_k0", core_k0, k2_0);
    chk("t4_new_k1", KW'(core_k1), KW'(k2_1));
    mk0 = k2_0; mk1 = k2_1;

    // test 5: reset with S1 and response both full
    rsp_ready = 1'b0; req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    step();
    req_valid = 2'b00; rst = 1'b0;
    step();
    rst = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("t5_rsp_valid", KW'(rsp_valid), KW'(1'b0));
    chk("t5_rsp_id", KW'(rsp_id), KW'(1'b0));
    chk("t5_rsp_c", KW'(rsp_c), '0);
    chk("t5_core_k0", core_k0, '0);
    chk("t5_core_k1", KW'(core_k1), '0);
    chk("t5_core_pte", KW'({core_p, core_t, core_enc}), '0);
    chk("t5_key_ready", KW'(key_ready), KW'(1'b0));
    chk("t5_req_ready", KW'(req_ready), KW'(2'b00));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_stale", KW'(rsp_valid), KW'(1'b0));
    end
    mk0 = '0; mk1 = '0;

    // randomized traffic against a two-slot in-order pipeline model
    for (int j = 0; j < KW/32; j++) rk0[j*32 +: 32] = $urandom();
    for (int j = 0; j < 16; j++) rtmp[j*32 +: 32] = $urandom();
    do_key(rk0, K1W'(rtmp), 2);
    ec = 0; ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_enc = 2'($urandom_range(0, 3));
      for (int j = 0; j < 8; j++) begin
        req_p[j*32 +: 32] = $urandom();
        req_t[j*32 +: 32] = $urandom();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_rv = (q.size() > 0) && (q[0].acc < ec);
      allowed = (q.size() < 2) || rsp_ready;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef BLINK_SCHED_FIXED_PRIO_EN
        idx = k;
`else
        idx = (ptr + k) % NREQ;
`endif
        if (win < 0 && req_valid[idx]) win = idx;
      end
      push = allowed && (win >= 0);
      e_rdy = push ? 2'(1 << win) : 2'b00;
      chk("rnd_ready", KW'(req_ready), KW'(e_rdy));
      chk("rnd_rsp_valid", KW'(rsp_valid), KW'(e_rv));
      if (e_rv) begin
        chk("rnd_rsp_id", KW'(rsp_id), KW'(q[0].id));
        chk("rnd_rsp_c", KW'(rsp_c), KW'(q[0].c));
      end
      pop = e_rv && rsp_ready;
      if (push) begin
        nitem.id = IDW'(win);
        nitem.c = core_f(req_enc[win], req_p[win*N +: N], req_t[win*TL +: TL], mk0, mk1);
        nitem.acc = 0;
      end
      step();
      ec++;
      if (pop) void'(q.pop_front());
      if (push) begin
        nitem.acc = ec;
        q.push_back(nitem);
        ptr = (win + 1) % NREQ;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
